// File: rtl/lv_pkg.sv
// Shared types and constants for the LV register-bank arbiter.
package lv_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAcc  = 2'd1,
    StRsp  = 2'd2
  } lv_reg_arb_st_e;

  localparam int unsigned LV_REG_ADDR_W      = 7;
  localparam int unsigned LV_REG_DATA_W      = 8;
  localparam int unsigned LV_REG_ARB_NUM_REQ = 3;

  // Requester indices on the register bank
  localparam int unsigned LV_REQ_SPI  = 0;
  localparam int unsigned LV_REQ_ISO  = 1;
  localparam int unsigned LV_REQ_BIST = 2;

endpackage

// File: rtl/lv_rr_arb.sv
// Combinational round-robin picker: the first set request after 'last' wins.
module lv_rr_arb #(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  int unsigned k;

  // Scan from lowest to highest priority so the highest-priority hit is written last
  always_comb begin
    gnt = '0;
    idx = '0;
    k   = 0;
    for (int i = int'(N); i >= 1; i--) begin
      k = (32'(last) + 32'(i)) % N;
      if (req[k]) begin
        gnt    = '0;
        gnt[k] = 1'b1;
        idx    = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/lv_reg_arb.sv
// Register-bank arbiter: round-robin access from NUM_REQ requesters to one
// register file, IDLE -> ACC -> RSP per access.
// Optional access timeout enabled by defining LV_REG_ARB_TMO_EN.
module lv_reg_arb
  import lv_pkg::*;
#(
  parameter int unsigned NUM_REQ = LV_REG_ARB_NUM_REQ,
  parameter int unsigned ADDR_W  = LV_REG_ADDR_W,
  parameter int unsigned DATA_W  = LV_REG_DATA_W,
  parameter int unsigned TMO_CYC = 255
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ-1:0]        i_wr,
  input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_wdata,
  output logic [NUM_REQ-1:0]        o_gnt,
  output logic [NUM_REQ-1:0]        o_ack,
  output logic [DATA_W-1:0]         o_rdata,
  output logic                      o_rf_req,
  output logic                      o_rf_wr,
  output logic [ADDR_W-1:0]         o_rf_addr,
  output logic [DATA_W-1:0]         o_rf_wdata,
  input  logic                      i_rf_ack,
  input  logic [DATA_W-1:0]         i_rf_rdata,
  output logic                      o_tmo_err,
  output logic                      o_busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  lv_reg_arb_st_e   state;
  logic [IDX_W-1:0] last_ptr;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] pick_idx;
  logic [NUM_REQ-1:0] pick_gnt;
  logic             tmo_hit;

  lv_rr_arb #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arb (
    .req  (i_req),
    .last (last_ptr),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

`ifdef LV_REG_ARB_TMO_EN
  logic [7:0] tmo_cnt;
  logic       tmo_err;

  // Count ACC cycles; zero outside ACC so every access starts from 0
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tmo_cnt <= '0;
    end else if (state == StAcc) begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  // Timeout fires in the TMO_CYC-th ACC cycle
  assign tmo_hit   = (state == StAcc) && (tmo_cnt == 8'(TMO_CYC - 1));
  assign o_tmo_err = tmo_err;
`else
  assign tmo_hit   = 1'b0;
  assign o_tmo_err = 1'b0;
`endif

  // Arbitration FSM with registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= StIdle;
      last_ptr   <= IDX_W'(NUM_REQ - 1);
      win_idx    <= '0;
      o_gnt      <= '0;
      o_ack      <= '0;
      o_rdata    <= '0;
      o_rf_req   <= 1'b0;
      o_rf_wr    <= 1'b0;
      o_rf_addr  <= '0;
      o_rf_wdata <= '0;
      o_busy     <= 1'b0;
`ifdef LV_REG_ARB_TMO_EN
      tmo_err    <= 1'b0;
`endif
    end else begin
      o_ack <= '0;
`ifdef LV_REG_ARB_TMO_EN
      tmo_err <= 1'b0;
`endif
      unique case (state)
        StIdle: begin
          if (|i_req) begin
            state      <= StAcc;
            win_idx    <= pick_idx;
            o_gnt      <= pick_gnt;
            o_rf_req   <= 1'b1;
            o_rf_wr    <= i_wr[pick_idx];
            o_rf_addr  <= i_addr[pick_idx*ADDR_W +: ADDR_W];
            o_rf_wdata <= i_wdata[pick_idx*DATA_W +: DATA_W];
            o_busy     <= 1'b1;
          end
        end
        StAcc: begin
          // An ack in the timeout cycle takes precedence over the timeout
          if (i_rf_ack || tmo_hit) begin
            state    <= StRsp;
            o_rf_req <= 1'b0;
            o_ack    <= o_gnt;
            o_rdata  <= (i_rf_ack && !o_rf_wr) ? i_rf_rdata : '0;
`ifdef LV_REG_ARB_TMO_EN
            tmo_err  <= !i_rf_ack;
`endif
          end
        end
        StRsp: begin
          state    <= StIdle;
          o_gnt    <= '0;
          o_rdata  <= '0;
          o_busy   <= 1'b0;
          last_ptr <= win_idx;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lv_reg_arb.sv
// Self-checking bench for lv_reg_arb; timeout checks run when LV_REG_ARB_TMO_EN is defined.
module tb_lv_reg_arb;

  localparam int NR = 3;
  localparam int AW = 7;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req = '0;
  logic [NR-1:0] wr = '0;
  logic [NR*AW-1:0] addr = '0;
  logic [NR*DW-1:0] wdata = '0;
  logic [NR-1:0] gnt, ack;
  logic [DW-1:0] rdata;
  logic          rf_req, rf_wr;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_wdata;
  logic          rf_ack = 1'b0;
  logic [DW-1:0] rf_rdata = '0;
  logic          tmo_err, busy;

  int checks = 0;
  int errors = 0;
  int last_ptr = NR - 1;

  always #5 clk = ~clk;

  lv_reg_arb #(
    .NUM_REQ (NR),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TMO_CYC (4)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req      (req),
    .i_wr       (wr),
    .i_addr     (addr),
    .i_wdata    (wdata),
    .o_gnt      (gnt),
    .o_ack      (ack),
    .o_rdata    (rdata),
    .o_rf_req   (rf_req),
    .o_rf_wr    (rf_wr),
    .o_rf_addr  (rf_addr),
    .o_rf_wdata (rf_wdata),
    .i_rf_ack   (rf_ack),
    .i_rf_rdata (rf_rdata),
    .o_tmo_err  (tmo_err),
    .o_busy     (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: first requester after the last owner, wrapping around
  function automatic int pick(input logic [NR-1:0] r, input int last);
    for (int i = 1; i <= NR; i++) begin
      if (r[(last + i) % NR]) return (last + i) % NR;
    end
    return -1;
  endfunction

  function automatic logic [63:0] all_outs();
    return {31'd0, gnt, ack, rdata, rf_req, rf_wr, rf_addr, rf_wdata, tmo_err, busy};
  endfunction

  task automatic do_reset();
    rst    = 1'b1;
    req    = '0;
    rf_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset outputs", all_outs(), 64'd0);
    rst      = 1'b0;
    last_ptr = NR - 1;
  endtask

  // Called at an IDLE negedge with inputs driven; returns at the following IDLE negedge
  task automatic txn(input int ack_dly, input bit drop, input bit scramble,
                     input logic [DW-1:0] rd, input string tag);
    int            w;
    logic          ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    w  = pick(req, last_ptr);
    ew = wr[w];
    ea = addr[w*AW +: AW];
    ed = wdata[w*DW +: DW];
    @(negedge clk);
    chk({tag, " gnt"}, 64'(gnt), 64'(1 << w));
    chk({tag, " cmd"}, {rf_req, rf_wr, rf_addr, rf_wdata, busy}, {1'b1, ew, ea, ed, 1'b1});
    if (scramble) begin
      addr  = 21'($urandom);
      wdata = 24'($urandom);
      wr    = ~wr;
    end
    if (drop) req[w] = 1'b0;
    repeat (ack_dly) begin
      @(negedge clk);
      chk({tag, " acc hold"}, {rf_req, rf_wr, rf_addr, rf_wdata, ack, tmo_err},
          {1'b1, ew, ea, ed, 3'b000, 1'b0});
    end
    rf_ack   = 1'b1;
    rf_rdata = rd;
    @(negedge clk);
    // Acks seen in RSP must be ignored
    rf_ack   = 1'($urandom_range(0, 1));
    rf_rdata = 8'($urandom);
    chk({tag, " ack"}, 64'(ack), 64'(1 << w));
    chk({tag, " rdata"}, 64'(rdata), ew ? 64'd0 : 64'(rd));
    chk({tag, " rsp"}, {rf_req, gnt, tmo_err, busy}, {1'b0, 3'(1 << w), 1'b0, 1'b1});
    @(negedge clk);
    rf_ack = 1'b0;
    chk({tag, " idle"}, {gnt, ack, busy, rf_req}, 8'd0);
    last_ptr = w;
  endtask

  initial begin
    do_reset();

    // Single read from the isolation-link requester
    req  = 3'b010;
    wr   = 3'b000;
    addr = '0;
    addr[1*AW +: AW] = 7'h15;
    txn(0, 1'b0, 1'b0, 8'hA5, "single");
    req = '0;
    @(negedge clk);

    // Fairness from reset with all requesters held
    do_reset();
    req   = 3'b111;
    wr    = 3'b010;
    addr  = 21'($urandom);
    wdata = 24'($urandom);
    for (int i = 0; i < 6; i++) txn(0, 1'b0, 1'b0, 8'($urandom), "fair");
    req = '0;

    // Command stability: owner changes its inputs during ACC
    req = 3'b100;
    wr  = 3'b100;
    txn(2, 1'b0, 1'b1, 8'h3C, "stable");

    // Request dropped during ACC still completes
    req = 3'b001;
    wr  = 3'b000;
    txn(1, 1'b1, 1'b0, 8'h5A, "drop");

    // Reset in the middle of an access
    req = 3'b010;
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("mid reset", all_outs(), 64'd0);
    req = '0;
    @(negedge clk);
    rf_ack = 1'b1;
    @(negedge clk);
    rf_ack = 1'b0;
    chk("mid reset hold", all_outs(), 64'd0);
    rst      = 1'b0;
    last_ptr = NR - 1;
    req      = 3'b101;
    txn(0, 1'b0, 1'b0, 8'h11, "after reset");
    req = '0;

    // Randomised traffic
    for (int i = 0; i < 30; i++) begin
      req   = 3'($urandom_range(1, 7));
      wr    = 3'($urandom);
      addr  = 21'($urandom);
      wdata = 24'($urandom);
      txn($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          8'($urandom), "rnd");
    end
    req = '0;

`ifdef LV_REG_ARB_TMO_EN
    // No ack: timeout after 4 ACC cycles
    req = 3'b010;
    wr  = 3'b000;
    @(negedge clk);
    req = '0;
    repeat (4) @(negedge clk);
    chk("tmo pulse", {tmo_err, ack, rdata}, {1'b1, 3'b010, 8'h00});
    @(negedge clk);
    chk("tmo idle", {tmo_err, ack, busy}, 5'd0);
    last_ptr = 1;
    // Ack on the timeout cycle wins
    req = 3'b100;
    txn(3, 1'b1, 1'b0, 8'h77, "tmo race");
`else
    // Without timeout the access waits for a late ack
    req = 3'b010;
    wr  = 3'b000;
    txn(1000, 1'b1, 1'b0, 8'hC3, "long wait");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
